mips_multicycle_controller: RTL

//  Main control FSM for the multicycle MIPS datapath (MIPSDatapath). Decodes the instruction word
//  and drives every datapath control input, one micro-step per cycle. Datapath A/B/MDR/ALUout

---
 rtl/mips_multicycle_controller.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: one micro-step per cycle, Moore outputs
// decoded from state and the instruction word, plus retirement counting and illegal-encoding report.
module mips_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             WriteRegSel,
  output logic             MemtoReg,
  output logic             WriteDataSel,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUoperation,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEM_ADDR = 4'd2,  S_LW_READ = 4'd3,
    S_LW_WB    = 4'd4,  S_SW_WRITE = 4'd5,  S_R_EXEC   = 4'd6,  S_R_WB    = 4'd7,
    S_I_EXEC   = 4'd8,  S_I_WB     = 4'd9,  S_BRANCH   = 4'd10, S_JUMP    = 4'd11,
    S_JAL      = 4'd12, S_JR       = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       reg_dst;
    logic       write_reg_sel;
    logic       mem_to_reg;
    logic       write_data_sel;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       done;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101, FN_SLT = 6'b101010, FN_JR  = 6'b001000;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t           state_r;
  state_t           next_s;
  ctrl_t            ctrl_s;
  logic [CNT_W-1:0] count_r;
  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic             unused_bits_s;

  assign opcode_s      = Instruction[31:26];
  assign funct_s       = Instruction[5:0];
  assign unused_bits_s = ^Instruction[25:6];

  // State register; reset aborts any instruction in flight and restarts at FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (ctrl_s.done) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    ctrl_s = '0;
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.ir_write  = 1'b1;
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.alu_src_b = 2'b01;
        ctrl_s.alu_op    = ALU_ADD;
        next_s           = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUout
        ctrl_s.alu_src_b = 2'b11;
        ctrl_s.alu_op    = ALU_ADD;
        case (opcode_s)
          OP_RTYPE: begin
            case (funct_s)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: next_s = S_R_EXEC;
              FN_JR:   next_s = S_JR;
              default: ctrl_s.illegal = 1'b1;
            endcase
          end
          OP_LW, OP_SW:     next_s = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: next_s = S_I_EXEC;
          OP_BEQ:           next_s = S_BRANCH;
          OP_J:             next_s = S_JUMP;
          OP_JAL:           next_s = S_JAL;
          default:          ctrl_s.illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b10;
        ctrl_s.alu_op    = ALU_ADD;
        next_s           = (opcode_s == OP_SW) ? S_SW_WRITE : S_LW_READ;
      end
      S_LW_READ: begin
        ctrl_s.iord     = 1'b1;
        ctrl_s.mem_read = 1'b1;
        next_s          = S_LW_WB;
      end
      S_LW_WB: begin
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.done       = 1'b1;
      end
      S_SW_WRITE: begin
        ctrl_s.iord      = 1'b1;
        ctrl_s.mem_write = 1'b1;
        ctrl_s.done      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        case (funct_s)
          FN_SUB:  ctrl_s.alu_op = ALU_SUB;
          FN_AND:  ctrl_s.alu_op = ALU_AND;
          FN_OR:   ctrl_s.alu_op = ALU_OR;
          FN_SLT:  ctrl_s.alu_op = ALU_SLT;
          default: ctrl_s.alu_op = ALU_ADD;
        endcase
        next_s = S_R_WB;
      end
      S_R_WB: begin
        ctrl_s.reg_dst   = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.done      = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b10;
        ctrl_s.alu_op    = (opcode_s == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_s           = S_I_WB;
      end
      S_I_WB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_op        = ALU_SUB;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_src        = 2'b10;
        ctrl_s.done          = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pc_write = 1'b1;
        ctrl_s.pc_src   = 2'b01;
        ctrl_s.done     = 1'b1;
      end
      S_JAL: begin
        // PC already holds the return address (PC+4) from FETCH
        ctrl_s.pc_write       = 1'b1;
        ctrl_s.pc_src         = 2'b01;
        ctrl_s.write_reg_sel  = 1'b1;
        ctrl_s.write_data_sel = 1'b1;
        ctrl_s.reg_write      = 1'b1;
        ctrl_s.done           = 1'b1;
      end
      S_JR: begin
        ctrl_s.pc_write = 1'b1;
        ctrl_s.pc_src   = 2'b11;
        ctrl_s.done     = 1'b1;
      end
      default: begin
        ctrl_s = '0;
        next_s = S_FETCH;
      end
    endcase
  end

  assign {PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegDst, WriteRegSel,
          MemtoReg, WriteDataSel, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUoperation,
          instr_done, illegal_instr} = rst ? 21'd0 : ctrl_s;
  assign state         = rst ? 4'd0 : state_r;
  assign retired_count = rst ? '0 : count_r;

endmodule
